adc_capture: RTL and testbench

Triggered snapshot buffer for the two-channel ADC stream. It sits beside the command decoder, on the same 32-bit AXI-Stream ADC bus: on a one-cycle start strobe it records DEPTH decimated sample pairs into an internal RAM. It then holds them for the PS to read back one word at a time, and reports its status through an 8-bit callback word that the command decoder can mux onto the PS GPIO return path.

---
 rtl/adc_capture.sv | 134 +++++++++++++
 tb/tb_adc_capture.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture.sv
// Triggered snapshot buffer: on a start edge, records DEPTH decimated {ch2, ch1}
// pairs from the ADC stream into a block RAM and holds them for word-wise readback.
module adc_capture #(
  parameter int unsigned ADC_DATA_WIDTH   = 16,
  parameter int unsigned AXIS_TDATA_WIDTH = 32,
  parameter int unsigned DEPTH            = 1024,
  parameter int unsigned ADDR_WIDTH       = 10,
  parameter int unsigned DECIM_WIDTH      = 8
) (
  input  logic                        clk,
  input  logic                        rst_ni,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata_i,
  input  logic                        s_axis_tvalid_i,
  input  logic                        start_i,
  input  logic [DECIM_WIDTH-1:0]      decim_i,
  input  logic [ADDR_WIDTH-1:0]       rd_addr_i,
  output logic [AXIS_TDATA_WIDTH-1:0] rd_data_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [ADDR_WIDTH:0]         wr_count_o,
  output logic [7:0]                  callback_o
);

  localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_DONE
  } state_e;

  state_e                   state_q, state_d;
  logic                     start_q;
  logic                     start_edge;
  logic [DECIM_WIDTH-1:0]   decim_r, decim_d;
  logic [DECIM_WIDTH-1:0]   dec_cnt, dec_cnt_d;
  logic [ADDR_WIDTH-1:0]    wr_ptr, wr_ptr_d;
  logic [CNT_WIDTH-1:0]     wr_count_d;
  logic                     busy_d, done_d;
  logic                     wr_en;

  logic [ADC_DATA_WIDTH-1:0]   ch1, ch2;
  logic [AXIS_TDATA_WIDTH-1:0] wr_data;

  // No reset on the array so it maps onto block RAM.
  logic [AXIS_TDATA_WIDTH-1:0] mem [DEPTH];

  assign ch1        = s_axis_tdata_i[ADC_DATA_WIDTH-1:0];
  assign ch2        = s_axis_tdata_i[2*ADC_DATA_WIDTH-1:ADC_DATA_WIDTH];
  assign wr_data    = {ch2, ch1};
  assign start_edge = start_i & ~start_q;

  // Next-state and datapath update; start edges are only honoured outside CAPTURE.
  always_comb begin
    state_d    = state_q;
    decim_d    = decim_r;
    dec_cnt_d  = dec_cnt;
    wr_ptr_d   = wr_ptr;
    wr_count_d = wr_count_o;
    wr_en      = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_edge) begin
          state_d    = ST_CAPTURE;
          decim_d    = decim_i;
          dec_cnt_d  = '0;
          wr_ptr_d   = '0;
          wr_count_d = '0;
        end
      end
      ST_CAPTURE: begin
        if (s_axis_tvalid_i) begin
          if (dec_cnt == '0) begin
            wr_en      = 1'b1;
            wr_ptr_d   = wr_ptr + ADDR_WIDTH'(1);
            wr_count_d = wr_count_o + CNT_WIDTH'(1);
            if (wr_count_d == FULL_COUNT) begin
              state_d = ST_DONE;
            end
          end
          dec_cnt_d = (dec_cnt == decim_r) ? '0 : dec_cnt + DECIM_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_CAPTURE);
    done_d = (state_d == ST_DONE);
  end

  // State and control registers.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      start_q    <= 1'b0;
      decim_r    <= '0;
      dec_cnt    <= '0;
      wr_ptr     <= '0;
      wr_count_o <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_i;
      decim_r    <= decim_d;
      dec_cnt    <= dec_cnt_d;
      wr_ptr     <= wr_ptr_d;
      wr_count_o <= wr_count_d;
      busy_o     <= busy_d;
      done_o     <= done_d;
    end
  end

  // RAM write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Read-first registered read port: a same-address write returns the old word.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_o <= '0;
    end else begin
      rd_data_o <= mem[rd_addr_i];
    end
  end

  assign callback_o = {4'b0000, |decim_r, 1'b0, done_o, busy_o};

endmodule

// File: tb/tb_adc_capture.sv
// Directed bench for adc_capture with DEPTH=16: capture, decimation, start
// handling, reset abort, restart and read-during-write behaviour.
module tb_adc_capture;

  logic        clk;
  logic        rst_ni;
  logic [31:0] s_axis_tdata_i;
  logic        s_axis_tvalid_i;
  logic        start_i;
  logic [7:0]  decim_i;
  logic [3:0]  rd_addr_i;
  logic [31:0] rd_data_o;
  logic        busy_o;
  logic        done_o;
  logic [4:0]  wr_count_o;
  logic [7:0]  callback_o;

  int total;
  int bad;
  int cnt;
  int t0;
  int t4;
  int ta;
  int tb;

  adc_capture #(
    .ADC_DATA_WIDTH  (16),
    .AXIS_TDATA_WIDTH(32),
    .DEPTH           (16),
    .ADDR_WIDTH      (4),
    .DECIM_WIDTH     (8)
  ) dut (
    .clk            (clk),
    .rst_ni         (rst_ni),
    .s_axis_tdata_i (s_axis_tdata_i),
    .s_axis_tvalid_i(s_axis_tvalid_i),
    .start_i        (start_i),
    .decim_i        (decim_i),
    .rd_addr_i      (rd_addr_i),
    .rd_data_o      (rd_data_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .wr_count_o     (wr_count_o),
    .callback_o     (callback_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, return at the next falling edge.
  task automatic step(input logic v, input logic s, input logic [31:0] d);
    s_axis_tvalid_i = v;
    start_i         = s;
    s_axis_tdata_i  = d;
    @(negedge clk);
    cnt++;
  endtask

  function automatic logic [31:0] ramp(input logic [15:0] tag, input int n);
    return {tag + 16'(n), 16'(n)};
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    cnt   = 0;
    rst_ni          = 1'b0;
    s_axis_tdata_i  = '0;
    s_axis_tvalid_i = 1'b0;
    start_i         = 1'b0;
    decim_i         = '0;
    rd_addr_i       = '0;

    // Reset values
    repeat (5) @(negedge clk);
    chk("rst_busy",  32'(busy_o),     32'd0);
    chk("rst_done",  32'(done_o),     32'd0);
    chk("rst_count", 32'(wr_count_o), 32'd0);
    chk("rst_rdata", rd_data_o,       32'd0);
    chk("rst_cb",    32'(callback_o), 32'h00);
    rst_ni = 1'b1;
    step(1'b1, 1'b0, 32'h1234_5678);
    step(1'b1, 1'b0, 32'h1234_5679);
    chk("idle_busy",  32'(busy_o),     32'd0);
    chk("idle_count", 32'(wr_count_o), 32'd0);

    // Continuous capture, decim 0
    decim_i = 8'd0;
    t0 = cnt;
    step(1'b1, 1'b1, ramp(16'h8000, cnt));
    chk("t1_busy",    32'(busy_o),     32'd1);
    chk("t1_cb_busy", 32'(callback_o), 32'h01);
    chk("t1_count0",  32'(wr_count_o), 32'd0);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, ramp(16'h8000, cnt));
      if (i == 14) begin
        chk("t1_done_early", 32'(done_o),     32'd0);
        chk("t1_count15",    32'(wr_count_o), 32'd15);
      end
    end
    chk("t1_done",    32'(done_o),     32'd1);
    chk("t1_busy_lo", 32'(busy_o),     32'd0);
    chk("t1_count16", 32'(wr_count_o), 32'd16);
    chk("t1_cb_done", 32'(callback_o), 32'h02);
    for (int i = 0; i < 16; i++) begin
      rd_addr_i = 4'(i);
      step(1'b0, 1'b0, 32'd0);
      chk("t1_read", rd_data_o, ramp(16'h8000, t0 + 1 + i));
    end

    // Decimation by 4 with tvalid on alternating cycles
    decim_i = 8'd3;
    step(1'b0, 1'b1, 32'd0);
    chk("t2_cb_busy", 32'(callback_o), 32'h09);
    for (int n = 0; n < 64; n++) begin
      step(1'b1, 1'b0, ramp(16'h4000, n));
      if (n == 59) begin
        chk("t2_count15", 32'(wr_count_o), 32'd15);
        chk("t2_done_lo", 32'(done_o),     32'd0);
      end
      if (n == 60) begin
        chk("t2_done",    32'(done_o),     32'd1);
        chk("t2_count16", 32'(wr_count_o), 32'd16);
      end
      step(1'b0, 1'b0, 32'd0);
    end
    chk("t2_cb_done", 32'(callback_o), 32'h0A);
    chk("t2_count",   32'(wr_count_o), 32'd16);
    for (int i = 0; i < 16; i++) begin
      rd_addr_i = 4'(i);
      step(1'b0, 1'b0, 32'd0);
      chk("t2_read", rd_data_o, ramp(16'h4000, 4 * i));
    end

    // Second start edge during capture is ignored
    decim_i = 8'd0;
    step(1'b1, 1'b1, ramp(16'h2000, cnt));
    for (int i = 0; i < 16; i++) begin
      if (i == 5) decim_i = 8'd5;
      step(1'b1, i == 5, ramp(16'h2000, cnt));
      if (i == 5) begin
        chk("t3_count6", 32'(wr_count_o), 32'd6);
        chk("t3_busy",   32'(busy_o),     32'd1);
        chk("t3_cb",     32'(callback_o), 32'h01);
      end
      if (i == 14) chk("t3_done_lo", 32'(done_o), 32'd0);
    end
    chk("t3_done",    32'(done_o),     32'd1);
    chk("t3_count16", 32'(wr_count_o), 32'd16);
    decim_i = 8'd0;

    // start_i held high for 40 cycles gives one capture
    t4 = cnt;
    step(1'b1, 1'b1, ramp(16'h3000, cnt));
    for (int i = 0; i < 39; i++) begin
      step(1'b1, 1'b1, ramp(16'h3000, cnt));
      if (i == 10) chk("t4_busy_mid", 32'(busy_o), 32'd1);
      if (i == 20) chk("t4_done_mid", 32'(done_o), 32'd1);
    end
    chk("t4_done",  32'(done_o),     32'd1);
    chk("t4_busy",  32'(busy_o),     32'd0);
    chk("t4_count", 32'(wr_count_o), 32'd16);
    step(1'b0, 1'b0, 32'd0);
    chk("t4_done_hold", 32'(done_o), 32'd1);

    // Reset asserted mid-capture
    t0 = cnt;
    step(1'b1, 1'b1, ramp(16'h5000, cnt));
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, ramp(16'h5000, cnt));
    chk("t5_count7", 32'(wr_count_o), 32'd7);
    #2 rst_ni = 1'b0;
    #1;
    chk("t5_busy_rst",  32'(busy_o),     32'd0);
    chk("t5_count_rst", 32'(wr_count_o), 32'd0);
    chk("t5_cb_rst",    32'(callback_o), 32'h00);
    @(negedge clk);
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, ramp(16'hEE00, cnt));
    chk("t5_busy_after",  32'(busy_o),     32'd0);
    chk("t5_count_after", 32'(wr_count_o), 32'd0);
    chk("t5_done_after",  32'(done_o),     32'd0);
    rd_addr_i = 4'd3;
    step(1'b0, 1'b0, 32'd0);
    chk("t5_kept_word", rd_data_o, ramp(16'h5000, t0 + 1 + 3));
    rd_addr_i = 4'd7;
    step(1'b0, 1'b0, 32'd0);
    chk("t5_no_write", rd_data_o, ramp(16'h3000, t4 + 1 + 7));

    // Restart from DONE with read-during-write
    ta = cnt;
    step(1'b1, 1'b1, ramp(16'h6000, cnt));
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, ramp(16'h6000, cnt));
    chk("t6_done_a", 32'(done_o), 32'd1);
    tb = cnt;
    step(1'b1, 1'b1, ramp(16'h7000, cnt));
    chk("t6_done_fall", 32'(done_o), 32'd0);
    chk("t6_busy",      32'(busy_o), 32'd1);
    for (int i = 0; i < 16; i++) begin
      rd_addr_i = 4'(i);
      step(1'b1, 1'b0, ramp(16'h7000, cnt));
      if (i == 0 || i == 9) chk("t6_rdw_old", rd_data_o, ramp(16'h6000, ta + 1 + i));
    end
    chk("t6_done_b", 32'(done_o), 32'd1);
    for (int i = 0; i < 16; i++) begin
      rd_addr_i = 4'(i);
      step(1'b0, 1'b0, 32'd0);
      chk("t6_read_new", rd_data_o, ramp(16'h7000, tb + 1 + i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
